// File: rtl/fpu_pack.sv
// fpu_pack: normalizes, rounds and encodes an unpacked ALU result into an IEEE word with fflags.
// Optional sticky flag accumulator is enabled by defining FPU_PACK_FFLAGS_EN.
module fpu_pack #(
    parameter int EXP      = 8,
    parameter int MANTISAA = 23,
    parameter int FLEN     = 1 + EXP + MANTISAA
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic signed [EXP+1:0] in_exp,
    input  logic [MANTISAA+3:0]   in_mant,
    input  logic                  in_nan,
    input  logic                  in_invalid,
    input  logic                  in_inf,
    input  logic [2:0]            rm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FLEN-1:0]       result,
    output logic [4:0]            fflags,
    output logic [4:0]            fflags_acc,
    input  logic                  fflags_clr
);

    localparam int EW = EXP + 2;
    localparam int MW = MANTISAA + 4;
    localparam logic signed [EW-1:0] C_ONE    = EW'(1);
    localparam logic signed [EW-1:0] C_MINEXP = EW'(-(MANTISAA + 3));
    localparam logic signed [EW:0]   C_ONE_X  = (EW + 1)'(1);
    localparam logic signed [EW:0]   C_OVF    = (EW + 1)'((1 << EXP) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_sign;
    logic signed [EW-1:0]   r_exp;
    logic [MW-1:0]          r_mant;
    logic                   r_nan;
    logic                   r_invalid;
    logic                   r_inf;
    logic [2:0]             r_rm;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [FLEN-1:0]        r_result;
    logic [4:0]             r_fflags;

    logic                   w_special;
    logic                   w_mant_zero;
    logic                   w_norm_done;
    logic [MW-1:0]          w_norm_mant;
    logic signed [EW-1:0]   w_norm_exp;
    logic [MW-1:0]          w_shr;
    logic [MW-1:0]          w_shl;
    logic                   w_inc;
    logic [MANTISAA+1:0]    w_sig_sum;
    logic                   w_hid_post;
    logic [MANTISAA-1:0]    w_frac_post;
    logic signed [EW:0]     w_exp_rnd;
    logic [EXP-1:0]         w_exp_field;
    logic                   w_ovf;
    logic                   w_nx;
    logic [FLEN-1:0]        w_result;
    logic [4:0]             w_fflags;

    // Rounding increment from guard/sticky/lsb, sign and rounding mode; unknown modes fall back to RNE.
    function automatic logic f_round_inc(input logic [2:0] mode, input logic sgn,
                                         input logic lsb, input logic grd, input logic stk);
        logic inc;
        case (mode)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn & (grd | stk);
            3'b011:  inc = ~sgn & (grd | stk);
            3'b100:  inc = grd;
            default: inc = grd & (stk | lsb);
        endcase
        return inc;
    endfunction

    assign w_special   = r_nan | r_invalid | r_inf;
    assign w_mant_zero = (r_mant == {MW{1'b0}});
    assign w_shr       = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
    assign w_shl       = {r_mant[MW-2:0], 1'b0};

    // One normalization step per cycle; w_norm_done means the mantissa is ready for rounding.
    always_comb begin
        w_norm_done = 1'b0;
        w_norm_mant = r_mant;
        w_norm_exp  = r_exp;
        if (w_special || w_mant_zero) begin
            w_norm_done = 1'b1;
        end else if (r_mant[MW-1]) begin
            w_norm_mant = w_shr;
            w_norm_exp  = r_exp + C_ONE;
        end else if (r_exp < C_ONE) begin
            // Far below the subnormal range every bit ends up in sticky anyway, so collapse at once.
            if (r_exp < C_MINEXP) begin
                w_norm_mant = {{(MW-1){1'b0}}, |r_mant};
                w_norm_exp  = C_ONE;
            end else begin
                w_norm_mant = w_shr;
                w_norm_exp  = r_exp + C_ONE;
            end
        end else if (!r_mant[MW-2] && (r_exp > C_ONE)) begin
            w_norm_mant = w_shl;
            w_norm_exp  = r_exp - C_ONE;
        end else begin
            w_norm_done = 1'b1;
        end
    end

    // Round the normalized significand and detect overflow of the rounded exponent.
    always_comb begin
        w_inc       = f_round_inc(r_rm, r_sign, r_mant[2], r_mant[1], r_mant[0]);
        w_sig_sum   = {1'b0, r_mant[MW-2:2]} + {{(MANTISAA+1){1'b0}}, w_inc};
        w_hid_post  = w_sig_sum[MANTISAA];
        w_frac_post = w_sig_sum[MANTISAA-1:0];
        w_exp_rnd   = $signed({r_exp[EW-1], r_exp});
        w_exp_field = {EXP{1'b0}};
        if (w_sig_sum[MANTISAA+1]) begin
            w_hid_post  = 1'b1;
            w_frac_post = {MANTISAA{1'b0}};
            w_exp_rnd   = $signed({r_exp[EW-1], r_exp}) + C_ONE_X;
        end else begin
            w_hid_post  = w_sig_sum[MANTISAA];
            w_frac_post = w_sig_sum[MANTISAA-1:0];
        end
        if (w_hid_post) begin
            w_exp_field = w_exp_rnd[EXP-1:0];
        end else begin
            w_exp_field = {EXP{1'b0}};
        end
        w_ovf = w_hid_post && (w_exp_rnd >= C_OVF);
        w_nx  = r_mant[1] | r_mant[0];
    end

    // Final encoding with specials first, then zero, overflow saturation and ordinary results.
    always_comb begin
        w_result = {FLEN{1'b0}};
        w_fflags = 5'b00000;
        if (r_nan || r_invalid) begin
            w_result = {1'b0, {EXP{1'b1}}, 1'b1, {(MANTISAA-1){1'b0}}};
            w_fflags = {r_invalid, 4'b0000};
        end else if (r_inf) begin
            w_result = {r_sign, {EXP{1'b1}}, {MANTISAA{1'b0}}};
        end else if (w_mant_zero) begin
            w_result = {r_sign, {(FLEN-1){1'b0}}};
        end else if (w_ovf) begin
            w_fflags = 5'b00101;
            case (r_rm)
                3'b001:  w_result = {r_sign, {(EXP-1){1'b1}}, 1'b0, {MANTISAA{1'b1}}};
                3'b010:  w_result = r_sign ? {r_sign, {EXP{1'b1}}, {MANTISAA{1'b0}}}
                                           : {r_sign, {(EXP-1){1'b1}}, 1'b0, {MANTISAA{1'b1}}};
                3'b011:  w_result = r_sign ? {r_sign, {(EXP-1){1'b1}}, 1'b0, {MANTISAA{1'b1}}}
                                           : {r_sign, {EXP{1'b1}}, {MANTISAA{1'b0}}};
                default: w_result = {r_sign, {EXP{1'b1}}, {MANTISAA{1'b0}}};
            endcase
        end else begin
            w_result = {r_sign, w_exp_field, w_frac_post};
            w_fflags = {3'b000, w_nx & ~r_mant[MW-2], w_nx};
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sign      <= 1'b0;
            r_exp       <= {EW{1'b0}};
            r_mant      <= {MW{1'b0}};
            r_nan       <= 1'b0;
            r_invalid   <= 1'b0;
            r_inf       <= 1'b0;
            r_rm        <= 3'b000;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= {FLEN{1'b0}};
            r_fflags    <= 5'b00000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_sign     <= in_sign;
                        r_exp      <= in_exp;
                        r_mant     <= in_mant;
                        r_nan      <= in_nan;
                        r_invalid  <= in_invalid;
                        r_inf      <= in_inf;
                        r_rm       <= rm;
                        r_in_ready <= 1'b0;
                        r_state    <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_norm_done) begin
                        r_state <= S_ROUND;
                    end else begin
                        r_mant <= w_norm_mant;
                        r_exp  <= w_norm_exp;
                    end
                end
                S_ROUND: begin
                    r_result    <= w_result;
                    r_fflags    <= w_fflags;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign fflags    = r_fflags;

`ifdef FPU_PACK_FFLAGS_EN
    logic [4:0] r_fflags_acc;
    logic       w_hs;

    assign w_hs = r_out_valid & out_ready;

    // Sticky flag accumulator; a clear coinciding with a handshake keeps only the new flags.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_fflags_acc <= 5'b00000;
        end else if (fflags_clr) begin
            r_fflags_acc <= w_hs ? r_fflags : 5'b00000;
        end else if (w_hs) begin
            r_fflags_acc <= r_fflags_acc | r_fflags;
        end
    end

    assign fflags_acc = r_fflags_acc;
`else
    logic w_unused_clr;

    assign w_unused_clr = fflags_clr;
    assign fflags_acc   = 5'b00000;
`endif

endmodule
